// File: rtl/store_merge_unit_if.sv
// Bundle between the store merge unit, its control unit and the data memory port.
// The master side drives the request and the memory read data; the slave side is the merge unit.
interface store_merge_unit_if;
    logic        start;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic [31:0] mem_data;
    logic [31:0] mem_addr;
    logic        mem_write;
    logic [31:0] mem_write_data;
    logic        busy;
    logic        done;
    logic        err;

    modport master (
        output start, size, addr, store_data, mem_data,
        input  mem_addr, mem_write, mem_write_data, busy, done, err
    );

    modport slave (
        input  start, size, addr, store_data, mem_data,
        output mem_addr, mem_write, mem_write_data, busy, done, err
    );
endinterface

// File: rtl/store_merge_unit.sv
// Word/half/byte store into word-wide memory; sub-word stores read the old word,
// replace its low half or byte with the register operand and write the result back.
//
// state | meaning
// IDLE  | waiting for start; busy low
// READ  | address held, waiting MEM_LAT cycles for the old word
// WRITE | single-cycle write enable with merged data
// DONE  | one-cycle done pulse (with err for an illegal size)
module store_merge_unit #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    store_merge_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] LAST_RD = 2'(MEM_LAT - 1);

    state_t      state_q;
    logic [1:0]  cnt_q;
    logic        half_q;
    logic [15:0] data_q;
    logic [31:0] mem_addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic        busy_q;
    logic        done_q;
    logic        err_q;

    logic [31:0] keep_mask_d;
    logic [31:0] merged_d;

    // Old-word bits kept by the merge; the rest come from the latched operand.
    always_comb begin
        keep_mask_d = half_q ? 32'hFFFF_0000 : 32'hFFFF_FF00;
        merged_d    = (bus.mem_data & keep_mask_d) | ({16'h0000, data_q} & ~keep_mask_d);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            half_q     <= 1'b0;
            data_q     <= 16'h0000;
            mem_addr_q <= 32'h0000_0000;
            wdata_q    <= 32'h0000_0000;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        mem_addr_q <= bus.addr;
                        data_q     <= bus.store_data[15:0];
                        half_q     <= (bus.size == 2'b01);
                        busy_q     <= 1'b1;
                        case (bus.size)
                            2'b00: begin
                                wdata_q <= bus.store_data;
                                we_q    <= 1'b1;
                                state_q <= WRITE;
                            end
                            2'b01, 2'b10: begin
                                cnt_q   <= 2'd0;
                                state_q <= READ;
                            end
                            default: begin
                                done_q  <= 1'b1;
                                err_q   <= 1'b1;
                                state_q <= DONE;
                            end
                        endcase
                    end
                end
                READ: begin
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == LAST_RD) begin
                        wdata_q <= merged_d;
                        we_q    <= 1'b1;
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_write      = we_q;
    assign bus.mem_write_data = wdata_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.err            = err_q;
endmodule

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
- Store-side counterpart of the load-path byte/half extractor: performs sw, sh and sb into word-wide data memory.
- sh/sb use a read-modify-write sequence. The old word is read, its low half (bits 15:0) or low byte (bits 7:0) is replaced with the register operand, and the merged word is written back.
- sw skips the read and writes directly.
- Sits between the control unit (start/busy/done) and the data memory port (address, write enable, write data, read data).

Parameters:
- MEM_LAT, 1, cycles from a stable MemAddr to valid MemData. Legal range 1..4.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- size  input  2  store size: 00 = word, 01 = half, 10 = byte, 11 = illegal.
- addr  input  32  word address of the target; latched at start.
- StoreData  input  32  register-B operand; latched at start.
- MemData  input  32  memory read data; valid MEM_LAT cycles after MemAddr.
- MemAddr  output  32  memory address; registered.
- MemWrite  output  1  memory write enable; high for exactly one cycle per legal store.
- MemWriteData  output  32  merged word to write; registered.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- err  output  1  high together with done when size was 11.

Behaviour:
- Reset (reset = 0, asynchronous): the following take effect immediately, with no clock edge required:
  - state = IDLE, read counter = 0;
  - MemAddr, MemWriteData = 0;
  - MemWrite, busy, done, err = 0.
- Reset mid-operation aborts the store. No write is issued; a WRITE cycle in progress is cut off at once.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - busy = 0.
  - On start = 1, latch addr into MemAddr and latch StoreData and size.
  - size 00: load MemWriteData = StoreData, go to WRITE.
  - size 01 or 10: clear the counter, go to READ.
  - size 11: go to DONE with err = 1; no memory access.
- READ:
  - MemAddr held; counter increments each cycle.
  - At the edge where counter = MEM_LAT-1, capture the merged word into MemWriteData and go to WRITE.
  - half: {MemData[31:16], StoreData[15:0]}.
  - byte: {MemData[31:8], StoreData[7:0]}.
- WRITE: MemWrite = 1 for this single cycle; MemAddr and MemWriteData stable; go to DONE.
- DONE: done = 1 for one cycle (err = 1 as well if illegal); go to IDLE.
- Latency from the start-sampling edge to the done cycle:
  - word: the WRITE cycle follows immediately, then done (done in cycle 2).
  - half/byte: READ occupies MEM_LAT cycles, then WRITE, then done (done in cycle MEM_LAT+2).
  - illegal: done in cycle 1.
- start while busy (READ/WRITE/DONE) is ignored and not queued.
- addr, StoreData and size changes after the start edge have no effect on the store in progress.
- StoreData bits above the store size are ignored (no sign or zero handling is needed on writes).
- MemWrite is never high outside WRITE.
- The earliest back-to-back start is the cycle after done (IDLE).

Test Plan:
- Reset: hold reset = 0 with start = 1, clk toggling -> all outputs 0, state stays IDLE. Release reset -> first start is accepted normally.
- sw: start, size = 00, addr = 0x40, StoreData = 0xDEADBEEF -> MemWrite = 1 in cycle 1 with MemAddr = 0x40 and MemWriteData = 0xDEADBEEF; done = 1 in cycle 2; no read phase.
- sh, MEM_LAT = 1: memory word 0x11223344, StoreData = 0xAAAABBBB -> one READ cycle; write 0x1122BBBB; done at cycle 3; err = 0.
- sb, MEM_LAT = 3: memory word 0x11223344, StoreData = 0x000000CC -> three READ cycles; write 0x112233CC; done at cycle 5; MemWrite high exactly once.
- Illegal size 11 -> no MemWrite; done = err = 1 in cycle 1. start pulses during a busy sb are ignored (exactly one write observed).
- Reset asserted during WRITE of an sh -> MemWrite drops immediately, no done pulse. Next sb after release completes with the correct merge.
